// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry/return sequencer driving the CSR write port and pipeline redirect.
module trap_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        mret_valid,
  input  logic        wfi_valid,
  input  logic [31:0] cur_pc,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic [31:0] mip_out,
  output logic        exc_ack,
  output logic        mret_ack,
  output logic        wfi_ack,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        stop_clock
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT, R_STATUS, WFI_WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, rpc_q, rpc_d, pend, status_trap, status_mret, vec_off;
  logic [3:0] irq_code;
  logic take_exc, take_irq, take_mret, take_wfi, exc_ack_q, mret_ack_q, wfi_ack_q, unused_ok;
  assign mip_out = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  assign pend = mip_out & mie_in;
  assign irq_code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
  assign take_exc = state_q == IDLE && exc_valid;
  assign take_irq = state_q == IDLE && !exc_valid && mstatus_in[3] && |pend;
  assign take_mret = state_q == IDLE && !exc_valid && !take_irq && mret_valid;
  assign take_wfi = state_q == IDLE && !exc_valid && !take_irq && !mret_valid && wfi_valid;
  assign status_trap = {mstatus_in[31:13], 2'b11, mstatus_in[10:8], mstatus_in[3], mstatus_in[6:4], 1'b0, mstatus_in[2:0]};
  assign status_mret = {mstatus_in[31:13], 2'b11, mstatus_in[10:8], 1'b1, mstatus_in[6:4], mstatus_in[7], mstatus_in[2:0]};
  assign vec_off = (mtvec_in[1:0] == 2'b01 && cause_q[31]) ? {26'b0, cause_q[3:0], 2'b00} : 32'b0;
  assign unused_ok = ^{mepc_in[1:0], mstatus_in[12:11], cause_q[30:4], epc_q[1:0]};
  // Trap operands are captured every idle cycle; they only matter on the cycle a trap is accepted.
  always_comb begin
    state_d = state_q;
    epc_d = epc_q;
    cause_d = cause_q;
    tval_d = tval_q;
    rpc_d = rpc_q;
    csr_we = 1'b0;
    csr_waddr = 12'h0;
    csr_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        state_d = (take_exc || take_irq) ? W_EPC : take_mret ? R_STATUS : take_wfi ? WFI_WAIT : IDLE;
        epc_d = exc_valid ? exc_pc : cur_pc;
        cause_d = exc_valid ? {28'b0, exc_code} : {1'b1, 27'b0, irq_code};
        tval_d = exc_valid ? exc_tval : 32'b0;
      end
      W_EPC: begin
        state_d = W_CAUSE;
        csr_we = 1'b1;
        csr_waddr = 12'h341;
        csr_wdata = {epc_q[31:2], 2'b00};
      end
      W_CAUSE: begin
        state_d = W_TVAL;
        csr_we = 1'b1;
        csr_waddr = 12'h342;
        csr_wdata = cause_q;
      end
      W_TVAL: begin
        state_d = W_STATUS;
        csr_we = 1'b1;
        csr_waddr = 12'h343;
        csr_wdata = tval_q;
      end
      W_STATUS: begin
        state_d = REDIRECT;
        csr_we = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = status_trap;
        rpc_d = {mtvec_in[31:2], 2'b00} + vec_off;
      end
      R_STATUS: begin
        state_d = REDIRECT;
        csr_we = 1'b1;
        csr_waddr = 12'h300;
        csr_wdata = status_mret;
        rpc_d = {mepc_in[31:2], 2'b00};
      end
      REDIRECT: state_d = IDLE;
      WFI_WAIT: state_d = (|pend || exc_valid) ? IDLE : WFI_WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q <= 32'b0;
      cause_q <= 32'b0;
      tval_q <= 32'b0;
      rpc_q <= RESET_PC;
      exc_ack_q <= 1'b0;
      mret_ack_q <= 1'b0;
      wfi_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q <= epc_d;
      cause_q <= cause_d;
      tval_q <= tval_d;
      rpc_q <= rpc_d;
      exc_ack_q <= take_exc;
      mret_ack_q <= take_mret;
      wfi_ack_q <= take_wfi;
    end
  end
  assign exc_ack = exc_ack_q;
  assign mret_ack = mret_ack_q;
  assign wfi_ack = wfi_ack_q;
  assign busy = state_q != IDLE;
  assign redirect_valid = state_q == REDIRECT;
  assign redirect_pc = rpc_q;
  assign stop_clock = state_q == WFI_WAIT && ~|pend;
endmodule
